// File: rtl/ex_muldiv_pkg.sv
// ============================================================================
// Module      : ex_muldiv_pkg
// Description : Shared encodings for the EX-stage RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_muldiv_pkg;

    localparam logic [6:0] c_funct7_muldiv = 7'b0000001;
    localparam logic [6:0] c_opcode_op     = 7'b0110011;

    localparam logic [2:0] c_op_mul    = 3'b000;
    localparam logic [2:0] c_op_mulh   = 3'b001;
    localparam logic [2:0] c_op_mulhsu = 3'b010;
    localparam logic [2:0] c_op_mulhu  = 3'b011;
    localparam logic [2:0] c_op_div    = 3'b100;
    localparam logic [2:0] c_op_divu   = 3'b101;
    localparam logic [2:0] c_op_rem    = 3'b110;
    localparam logic [2:0] c_op_remu   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : ex_muldiv_pkg

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ============================================================================
// Module      : ex_muldiv
// Description : Iterative RV32M multiply (radix-2 shift-add) and restoring
//               divide; stalls the front end for 33 cycles per operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0]   c_min   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]   c_one   = XLEN'(1);
    localparam logic [2*XLEN-1:0] c_one2x = (2*XLEN)'(1);

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] x);
        return (~x) + c_one;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] x);
        return (~x) + c_one2x;
    endfunction

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     mag_b_q, mag_b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                w_sa, w_sb, w_special;
    logic [XLEN-1:0]     w_mag_a, w_mag_b, w_special_res;
    logic [XLEN:0]       w_mul_sum, w_shift, w_trial;
    logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_step, w_prod;
    logic [XLEN-1:0]     w_quo, w_rem, w_final;

    always_comb begin
        // Operand signedness decoded from the live funct3 at acceptance.
        w_sa = (op != c_op_mulhu) && (op != c_op_divu) && (op != c_op_remu) && a[XLEN-1];
        w_sb = ((op == c_op_mul) || (op == c_op_mulh) || (op == c_op_div) || (op == c_op_rem))
               && b[XLEN-1];
        w_mag_a = w_sa ? neg_x(a) : a;
        w_mag_b = w_sb ? neg_x(b) : b;

        w_special = op[2] && ((b == '0) || (!op[0] && (a == c_min) && (b == '1)));
        if (b == '0) begin
            w_special_res = op[1] ? a : '1;
        end else begin
            w_special_res = op[1] ? '0 : c_min;
        end

        // The accumulator is {partial product, multiplier} or {remainder, quotient}.
        w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};
        w_shift    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        w_trial    = w_shift - {1'b0, mag_b_q};
        w_div_next = w_trial[XLEN] ? {w_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {w_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        w_step     = op_q[2] ? w_div_next : w_mul_next;

        w_prod  = neg_res_q ? neg_2x(w_step) : w_step;
        w_quo   = neg_res_q ? neg_x(w_step[XLEN-1:0]) : w_step[XLEN-1:0];
        w_rem   = neg_rem_q ? neg_x(w_step[2*XLEN-1:XLEN]) : w_step[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            w_final = op_q[1] ? w_rem : w_quo;
        end else begin
            w_final = (op_q == c_op_mul) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mag_b_d   = mag_b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        result_d  = result_q;
        stall     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    stall     = 1'b1;
                    op_d      = op;
                    mag_b_d   = w_mag_b;
                    acc_d     = {{XLEN{1'b0}}, w_mag_a};
                    cnt_d     = 5'd0;
                    neg_res_d = w_sa ^ w_sb;
                    neg_rem_d = w_sa;
                    if (w_special) begin
                        result_d = w_special_res;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = w_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = w_final;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            mag_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mag_b_q   <= mag_b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule : ex_muldiv

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Self-checking bench for ex_muldiv against a cycle-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv;

    localparam logic [31:0] c_min = 32'h8000_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural RV32M result from plain 64-bit / integer arithmetic.
    function automatic logic [31:0] ref_calc(input logic [2:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
        logic [63:0] xa, yb, p;
        int sx, sy;
        xa = (f != 3'd3 && x[31]) ? {32'hFFFF_FFFF, x} : {32'h0, x};
        yb = (f <= 3'd1 && y[31]) ? {32'hFFFF_FFFF, y} : {32'h0, y};
        p  = xa * yb;
        sx = $signed(x);
        sy = $signed(y);
        case (f)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == c_min && y == 32'hFFFF_FFFF) return c_min;
                return 32'(sx / sy);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == c_min && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sx % sy);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] x,
                                      input logic [31:0] y);
        return f[2] && ((y == 0) || (!f[0] && x == c_min && y == 32'hFFFF_FFFF));
    endfunction

    // Cycle model: remaining busy cycles, done-cycle flag, visible and pending result.
    int          m_run  = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res  = 32'h0;
    logic [31:0] m_pend = 32'h0;

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outputs", {stall, done, 30'h0} | result, 32'h0);
            m_run  = 0;
            m_done = 1'b0;
            m_res  = 32'h0;
        end else begin
            chk("stall", {31'h0, stall},
                {31'h0, (m_run > 0) || (!m_done && start && !flush)});
            chk("done", {31'h0, done}, {31'h0, m_done});
            chk("result", result, m_res);
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_run > 0) begin
                if (flush) begin
                    m_run = 0;
                end else begin
                    m_run--;
                    if (m_run == 0) begin
                        m_done = 1'b1;
                        m_res  = m_pend;
                    end
                end
            end else if (start && !flush) begin
                if (is_special(op, a, b)) begin
                    m_done = 1'b1;
                    m_res  = ref_calc(op, a, b);
                end else begin
                    m_run  = 32;
                    m_pend = ref_calc(op, a, b);
                end
            end
        end
    end

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_lit(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp, input int lat);
        int t0;
        bit got;
        @(posedge clk); #1;
        op = f; a = x; b = y; start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        chk("stall_accept", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom);
        wait_done(got);
        if (!got) begin
            chk("done_timeout", 32'h0, 32'h1);
        end else begin
            chk("latency", 32'(cyc - t0), 32'(lat));
            chk("result_lit", result, exp);
        end
    endtask

    initial begin
        int t0;
        bit got;
        bit saw_done;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Hand-computed expectations pinning the arithmetic and the latency.
        run_lit(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_lit(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_lit(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_lit(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_lit(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_lit(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_lit(3'd5, 32'd100,       32'd7,         32'd14,        33);
        run_lit(3'd7, 32'd100,       32'd7,         32'd2,         33);
        run_lit(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_lit(3'd6, 32'd5,         32'd0,         32'd5,         1);
        run_lit(3'd4, c_min,         32'hFFFF_FFFF, c_min,         1);
        run_lit(3'd6, c_min,         32'hFFFF_FFFF, 32'h0,         1);

        // Back-to-back MULs with start held through DONE.
        @(posedge clk); #1;
        op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
        t0 = cyc;
        wait_done(got);
        chk("b2b_first_done", {31'h0, got}, 32'h1);
        chk("b2b_first_lat", 32'(cyc - t0), 32'd33);
        chk("b2b_first_res", result, 32'd12);
        @(posedge clk); #1;
        a = 32'd5; b = 32'd6;
        wait_done(got);
        chk("b2b_second_done", {31'h0, got}, 32'h1);
        chk("b2b_second_lat", 32'(cyc - t0), 32'd67);
        chk("b2b_second_res", result, 32'd30);
        @(posedge clk); #1;
        start = 1'b0;

        // Flush five cycles into a multiply.
        @(posedge clk); #1;
        op = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t0 + 5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_stall", {31'h0, stall}, 32'h0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("flush_no_done", {31'h0, saw_done}, 32'h0);
        chk("flush_result_held", result, 32'd30);

        // Asynchronous reset mid-operation.
        @(posedge clk); #1;
        op = 3'd0; a = 32'd11; b = 32'd13; start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t0 + 10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_stall", {31'h0, stall}, 32'h0);
        chk("async_rst_done", {31'h0, done}, 32'h0);
        chk("async_rst_result", result, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Randomized traffic; the monitor model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom % 3) != 0;
            flush = ($urandom % 25) == 0;
            op    = 3'($urandom);
            case ($urandom % 8)
                0: a = c_min;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom % 8)
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'(($urandom % 16));
                default: b = $urandom;
            endcase
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        repeat (40) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ex_muldiv

`default_nettype wire
